// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic operand feeders.
package systolic_pkg;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    // Number of skewed steps needed to drain one bank across all lanes.
    function automatic int unsigned stream_steps(input int unsigned channels,
                                                 input int unsigned depth);
        return depth + channels - 1;
    endfunction

endpackage

// File: rtl/operand_bank_rf.sv
// One operand bank: serial write port, one combinational read port per lane.
module operand_bank_rf #(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned LANE_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned ELEM_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                           clk_i,
    input  logic                           wr_en_i,
    input  logic [LANE_W-1:0]              wr_lane_i,
    input  logic [ELEM_W-1:0]              wr_elem_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    input  logic [CHANNELS*ELEM_W-1:0]     rd_elem_i,
    output logic [CHANNELS*DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem [CHANNELS][DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_lane_i][wr_elem_i] <= wr_data_i;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_rd
        logic [ELEM_W-1:0] elem;
        assign elem = rd_elem_i[c*ELEM_W +: ELEM_W];
        // Out-of-range element indices read as zero rather than X.
        assign rd_data_o[c*DATA_WIDTH +: DATA_WIDTH] =
            (32'(elem) < DEPTH) ? mem[c][elem] : '0;
    end

endmodule

// File: rtl/skewed_operand_buffer.sv
// Ping-pong operand store: one bank fills serially while the other streams
// out as a diagonal wavefront (lane c delayed by c cycles).
module skewed_operand_buffer
    import systolic_pkg::*;
#(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_en_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    input  logic                           wr_reset_i,
    output logic                           wr_ready_o,
    output logic                           wr_overflow_o,
    output logic [1:0]                     full_banks_o,
    input  logic                           start_i,
    input  logic                           stall_i,
    output logic                           busy_o,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_o,
    output logic [CHANNELS-1:0]            valid_o,
    output logic [CHANNELS-1:0]            last_o,
    output logic                           done_o
);

    localparam int unsigned STEPS  = stream_steps(CHANNELS, DEPTH);
    localparam int unsigned T_W    = $clog2(STEPS + 1);
    localparam int unsigned LANE_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned ELEM_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rd_state_e   state;
    bank_state_e bank_st [2];
    logic        fill_bank;
    logic        rd_bank;
    logic [LANE_W-1:0] wr_lane;
    logic [ELEM_W-1:0] wr_elem;
    logic [T_W-1:0]    step;

    logic accept, start_ok, advance, finish, load;
    logic [T_W-1:0] nxt_step;
    logic [T_W:0]   diff;
    logic [CHANNELS*ELEM_W-1:0]     rd_elem;
    logic [CHANNELS-1:0]            lane_valid;
    logic [CHANNELS-1:0]            lane_last;
    logic [CHANNELS*DATA_WIDTH-1:0] bank_data [2];
    logic [CHANNELS*DATA_WIDTH-1:0] masked_data;

    assign wr_ready_o   = (bank_st[fill_bank] == BANK_EMPTY);
    assign full_banks_o = {1'b0, bank_st[0] == BANK_FULL} + {1'b0, bank_st[1] == BANK_FULL};
    assign busy_o       = (state == RD_STREAM);

    assign accept   = wr_en_i && wr_ready_o && !wr_reset_i;
    // Banks fill and drain in strict alternation, so rd_bank is always the oldest FULL bank.
    assign start_ok = (state == RD_IDLE) && start_i && (bank_st[rd_bank] == BANK_FULL);
    assign advance  = (state == RD_STREAM) && !stall_i;
    assign finish   = advance && (step == T_W'(STEPS - 1));
    assign load     = start_ok || (advance && !finish);
    assign nxt_step = start_ok ? '0 : step + 1'b1;

    always_comb begin
        rd_elem     = '0;
        lane_valid  = '0;
        lane_last   = '0;
        diff        = '0;
        masked_data = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            // Negative (t - c) shows up as the extra top bit being set.
            diff = {1'b0, nxt_step} - (T_W + 1)'(c);
            lane_valid[c] = !diff[T_W] && (diff[T_W-1:0] < T_W'(DEPTH));
            lane_last[c]  = lane_valid[c] && (diff[T_W-1:0] == T_W'(DEPTH - 1));
            rd_elem[c*ELEM_W +: ELEM_W] = diff[ELEM_W-1:0];
        end
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (lane_valid[c]) begin
                masked_data[c*DATA_WIDTH +: DATA_WIDTH] =
                    bank_data[rd_bank][c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        operand_bank_rf #(
            .CHANNELS  (CHANNELS),
            .DEPTH     (DEPTH),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_bank (
            .clk_i    (clk_i),
            .wr_en_i  (accept && (fill_bank == 1'(b))),
            .wr_lane_i(wr_lane),
            .wr_elem_i(wr_elem),
            .wr_data_i(wr_data_i),
            .rd_elem_i(rd_elem),
            .rd_data_o(bank_data[b])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= RD_IDLE;
            bank_st[0]    <= BANK_EMPTY;
            bank_st[1]    <= BANK_EMPTY;
            fill_bank     <= 1'b0;
            rd_bank       <= 1'b0;
            wr_lane       <= '0;
            wr_elem       <= '0;
            step          <= '0;
            data_o        <= '0;
            valid_o       <= '0;
            last_o        <= '0;
            done_o        <= 1'b0;
            wr_overflow_o <= 1'b0;
        end else begin
            done_o <= finish;
            if (wr_en_i && !wr_ready_o) begin
                wr_overflow_o <= 1'b1;
            end

            if (wr_reset_i) begin
                wr_lane <= '0;
                wr_elem <= '0;
            end else if (accept) begin
                if (wr_elem == ELEM_W'(DEPTH - 1)) begin
                    wr_elem <= '0;
                    if (wr_lane == LANE_W'(CHANNELS - 1)) begin
                        wr_lane            <= '0;
                        bank_st[fill_bank] <= BANK_FULL;
                        fill_bank          <= ~fill_bank;
                    end else begin
                        wr_lane <= wr_lane + 1'b1;
                    end
                end else begin
                    wr_elem <= wr_elem + 1'b1;
                end
            end

            if (start_ok) begin
                state <= RD_STREAM;
            end
            if (load) begin
                step    <= nxt_step;
                data_o  <= masked_data;
                valid_o <= lane_valid;
                last_o  <= lane_last;
            end else if (finish) begin
                state            <= RD_IDLE;
                step             <= '0;
                data_o           <= '0;
                valid_o          <= '0;
                last_o           <= '0;
                bank_st[rd_bank] <= BANK_EMPTY;
                rd_bank          <= ~rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_skewed_operand_buffer.sv
// Bench for skewed_operand_buffer: directed vectors plus randomized traffic
// checked against a queue-based model of the banks and the skewed stream.
module tb_skewed_operand_buffer;

    localparam int CH = 4;
    localparam int DP = 3;
    localparam int DW = 16;
    localparam int S  = DP + CH - 1;
    localparam int NW = CH * DP;

    typedef logic [NW*DW-1:0] mat_t;

    typedef struct {
        int          cyc;
        int          lane;
        logic [15:0] data;
        logic        valid;
        logic        last;
        logic        done;
    } vec_t;

    logic clk;
    logic rst, wr_en, wr_reset, start, stall;
    logic [DW-1:0] wr_data;
    logic wr_ready, wr_overflow, busy, done;
    logic [1:0] full_banks;
    logic [CH*DW-1:0] data;
    logic [CH-1:0] valid, last;

    int checks = 0;
    int failures = 0;

    // Reference model state
    mat_t        full_q[$];
    logic [DW-1:0] part_q[$];
    mat_t        cur;
    bit          m_active;
    int          m_t;
    bit          m_done;
    bit          m_ovf;

    skewed_operand_buffer #(
        .CHANNELS  (CH),
        .DEPTH     (DP),
        .DATA_WIDTH(DW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .wr_en_i      (wr_en),
        .wr_data_i    (wr_data),
        .wr_reset_i   (wr_reset),
        .wr_ready_o   (wr_ready),
        .wr_overflow_o(wr_overflow),
        .full_banks_o (full_banks),
        .start_i      (start),
        .stall_i      (stall),
        .busy_o       (busy),
        .data_o       (data),
        .valid_o      (valid),
        .last_o       (last),
        .done_o       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        int fb;
        bit ready;
        mat_t m;
        fb = full_q.size() + (m_active ? 1 : 0);
        ready = (fb < 2);
        if (rst) begin
            full_q.delete();
            part_q.delete();
            m_active = 0;
            m_t = 0;
            m_done = 0;
            m_ovf = 0;
            return;
        end
        m_done = 0;
        if (m_active) begin
            if (!stall) begin
                if (m_t == S - 1) begin
                    m_active = 0;
                    m_done = 1;
                end else begin
                    m_t++;
                end
            end
        end else if (start && full_q.size() > 0) begin
            cur = full_q.pop_front();
            m_active = 1;
            m_t = 0;
        end
        if (wr_en && !ready) m_ovf = 1;
        if (wr_reset) begin
            part_q.delete();
        end else if (wr_en && ready) begin
            part_q.push_back(wr_data);
            if (part_q.size() == NW) begin
                m = '0;
                for (int i = 0; i < NW; i++) m[i*DW +: DW] = part_q[i];
                full_q.push_back(m);
                part_q.delete();
            end
        end
    endtask

    task automatic check_model();
        logic [CH*DW-1:0] ed;
        logic [CH-1:0] ev, el;
        int e;
        int fb;
        ed = '0;
        ev = '0;
        el = '0;
        for (int c = 0; c < CH; c++) begin
            e = m_t - c;
            if (m_active && e >= 0 && e < DP) begin
                ed[c*DW +: DW] = cur[(c*DP + e)*DW +: DW];
                ev[c] = 1'b1;
                el[c] = (e == DP - 1);
            end
        end
        fb = full_q.size() + (m_active ? 1 : 0);
        chk("data_o", data, ed);
        chk("valid_o", valid, ev);
        chk("last_o", last, el);
        chk("done_o", done, m_done);
        chk("busy_o", busy, m_active);
        chk("wr_ready_o", wr_ready, fb < 2);
        chk("wr_overflow_o", wr_overflow, m_ovf);
        chk("full_banks_o", full_banks, fb);
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic write_words(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1;
            wr_data = DW'(base + i);
            cyc();
        end
        wr_en = 1'b0;
    endtask

    function automatic logic [15:0] lane_of(input logic [CH*DW-1:0] d, input int c);
        return d[c*DW +: DW];
    endfunction

    vec_t vt[11];
    logic [CH*DW-1:0] cap_d[10];
    logic [CH-1:0]    cap_v[10];
    logic [CH-1:0]    cap_l[10];
    logic             cap_done[10];

    initial begin
        int done_cyc;
        int seen;

        vt[0]  = '{1, 0, 16'd1,  1'b1, 1'b0, 1'b0};
        vt[1]  = '{2, 0, 16'd2,  1'b1, 1'b0, 1'b0};
        vt[2]  = '{3, 0, 16'd3,  1'b1, 1'b1, 1'b0};
        vt[3]  = '{4, 0, 16'd0,  1'b0, 1'b0, 1'b0};
        vt[4]  = '{1, 3, 16'd0,  1'b0, 1'b0, 1'b0};
        vt[5]  = '{4, 3, 16'd10, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{5, 3, 16'd11, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{6, 3, 16'd12, 1'b1, 1'b1, 1'b0};
        vt[8]  = '{7, 0, 16'd0,  1'b0, 1'b0, 1'b1};
        vt[9]  = '{3, 2, 16'd7,  1'b1, 1'b0, 1'b0};
        vt[10] = '{4, 1, 16'd6,  1'b1, 1'b1, 1'b0};

        rst = 0; wr_en = 0; wr_reset = 0; start = 0; stall = 0; wr_data = '0;
        m_active = 0; m_t = 0; m_done = 0; m_ovf = 0; cur = '0;
        @(posedge clk);
        #1;

        // Reset values
        do_reset();
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ready", wr_ready, 1);
        chk("rst_full", full_banks, 0);

        // Basic stream, table-driven
        write_words(1, 12);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cap_d[k] = data;
            cap_v[k] = valid;
            cap_l[k] = last;
            cap_done[k] = done;
            cyc();
        end
        foreach (vt[i]) begin
            chk($sformatf("vec%0d_data", i), lane_of(cap_d[vt[i].cyc], vt[i].lane), vt[i].data);
            chk($sformatf("vec%0d_valid", i), cap_v[vt[i].cyc][vt[i].lane], vt[i].valid);
            chk($sformatf("vec%0d_last", i), cap_l[vt[i].cyc][vt[i].lane], vt[i].last);
            chk($sformatf("vec%0d_done", i), cap_done[vt[i].cyc], vt[i].done);
        end

        // Ping-pong: B completes while A streams; second start lands at cycle 7
        do_reset();
        write_words(1, 12);
        write_words(101, 6);
        chk("pp_full_before", full_banks, 1);
        for (int k = 0; k < 12; k++) begin
            start = 1'b1;
            wr_en = (k < 6);
            wr_data = DW'(107 + k);
            cyc();
            if (k + 1 == 6) chk("pp_full_two", full_banks, 2);
            if (k + 1 == 7) begin
                chk("pp_done_c7", done, 1);
                chk("pp_full_one", full_banks, 1);
            end
            if (k + 1 == 8) chk("pp_lane0_c8", lane_of(data, 0), 101);
        end
        start = 1'b0;
        wr_en = 1'b0;
        for (int k = 0; k < 8; k++) cyc();

        // Overflow: both banks full, extra writes dropped
        do_reset();
        write_words(1, 12);
        write_words(51, 12);
        write_words(900, 3);
        chk("ovf_ready", wr_ready, 0);
        chk("ovf_flag", wr_overflow, 1);
        chk("ovf_full", full_banks, 2);
        for (int k = 0; k < 16; k++) begin
            start = 1'b1;
            cyc();
            if (k + 1 == 8) chk("ovf_lane0_second", lane_of(data, 0), 51);
        end
        start = 1'b0;
        chk("ovf_sticky", wr_overflow, 1);
        chk("ovf_drained", full_banks, 0);

        // Stall in cycles 2-3 pushes done from cycle 7 to 9
        do_reset();
        write_words(1, 12);
        start = 1'b1;
        cyc();
        start = 1'b0;
        done_cyc = -1;
        for (int k = 1; k <= 12; k++) begin
            if (done && done_cyc < 0) done_cyc = k;
            if (k == 4) chk("stall_hold_lane0", lane_of(data, 0), 2);
            stall = (k == 2 || k == 3);
            cyc();
        end
        stall = 1'b0;
        chk("stall_done_cycle", done_cyc, 9);

        // Write-pointer reset discards the partial fill
        do_reset();
        write_words(900, 5);
        wr_reset = 1'b1;
        cyc();
        wr_reset = 1'b0;
        write_words(201, 12);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("wrst_lane0_c1", lane_of(data, 0), 201);
        cyc();
        cyc();
        chk("wrst_lane0_c3", lane_of(data, 0), 203);
        for (int k = 0; k < 6; k++) cyc();

        // Reset mid-stream aborts without done
        do_reset();
        write_words(1, 12);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mrst_data", data, 0);
        chk("mrst_full", full_banks, 0);
        chk("mrst_busy", busy, 0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            start = 1'b1;
            cyc();
            if (busy || done) seen++;
        end
        start = 1'b0;
        chk("mrst_start_ignored", seen, 0);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            rst      = ($urandom_range(0, 199) == 0);
            wr_en    = ($urandom_range(0, 9) < 6);
            wr_data  = DW'($urandom);
            wr_reset = ($urandom_range(0, 49) == 0);
            start    = ($urandom_range(0, 3) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/skewed_operand_buffer.md
Name: skewed_operand_buffer

Overview:
- Parametrised successor to the single-bank row/column input queues that feed the mesh.
- Double-buffered operand store for CHANNELS lanes × DEPTH elements.
- One bank is filled through a serial write port while the other streams out diagonally skewed: lane c is delayed c cycles, which is the wavefront the mesh expects.
- Adds rectangular sizing, ping-pong banking, a stall input, per-lane valid/last and an overflow flag.
- Instantiated twice: once for the north (weights) side, once for the west (data) side.

Parameters:
- CHANNELS, 8, number of lanes (mesh edge length on this side); ≥2.
- DEPTH, 8, elements per lane per operand matrix (inner dimension K); ≥1.
- DATA_WIDTH, 32, element width in bits.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- wr_en_i  in  1  write strobe; ignored when wr_ready_o=0.
- wr_data_i  in  DATA_WIDTH  write word.
- wr_reset_i  in  1  discard partial fill of the current fill bank.
- wr_ready_o  out  1  fill bank available.
- wr_overflow_o  out  1  sticky: wr_en_i seen while wr_ready_o=0.
- full_banks_o  out  2  number of FULL banks (0..2).
- start_i  in  1  request to stream the oldest FULL bank.
- stall_i  in  1  freeze the stream.
- busy_o  out  1  state STREAM.
- data_o  out  CHANNELS×DATA_WIDTH  lane c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- valid_o  out  CHANNELS  per-lane element valid.
- last_o  out  CHANNELS  per-lane final element (index DEPTH-1).
- done_o  out  1  one-cycle pulse at end of stream.

Behaviour:
Reset:
- One clock; reset is synchronous and active-high.
- Reset clears both banks to EMPTY, write pointer 0, fill bank 0, read bank 0, state IDLE.
- Output reset values: data_o=0, valid_o=0, last_o=0, done_o=0, busy_o=0, wr_overflow_o=0, full_banks_o=0, wr_ready_o=1.
- Reset mid-stream or mid-fill aborts immediately; no done_o is issued.

Write path:
- Lane-major addressing: the w-th accepted word (w = 0..CHANNELS*DEPTH-1) goes to lane w/DEPTH, element w%DEPTH of the fill bank.
- The accepted word at w = CHANNELS*DEPTH-1 marks the bank FULL at that edge.
- The write pointer then resets, and fill moves to the other bank.
- wr_ready_o = fill bank is EMPTY (registered).
- wr_reset_i: write pointer goes to 0 and bank contents are don't-care; it has priority over a simultaneous wr_en_i.

Read FSM (IDLE, STREAM):
- IDLE→STREAM when start_i=1 and full_banks_o≥1 at an edge. Step counter t=0; the read bank is the oldest FULL bank (banks drain in fill order).
- start_i is ignored while in STREAM or when no bank is FULL.
- A bank completing in the same cycle as start_i is not visible until the next cycle.
- Number of stream steps S = DEPTH+CHANNELS-1; t is $clog2(S+1) bits.
- At step t, lane c presents element t-c if 0 ≤ t-c < DEPTH, with valid_o[c]=1; otherwise data 0 and valid 0.
- last_o[c] = valid_o[c] & (t-c == DEPTH-1).

Timing:
- Outputs are registered. With the accepting cycle numbered 0, step t is on the outputs in cycle t+1; step S-1 is in cycle S.
- In cycle S+1: done_o=1, valid_o=0, state IDLE, read bank EMPTY.
- A start_i sampled at the end of cycle S+1 begins the next matrix, so there is a one-bubble gap between matrices.

Stall and concurrency:
- stall_i=1 in a cycle means the ending edge does not advance t, and all outputs hold.
- stall_i in IDLE has no effect.
- A bank freed by done_o is writable from the following cycle; fill and stream proceed concurrently on different banks.
- Both banks FULL implies wr_ready_o=0; any wr_en_i then sets wr_overflow_o, which stays set until rst_i. The word is dropped.

Decomposition:
- systolic_pkg: bank_state_e {BANK_EMPTY, BANK_FULL}, rd_state_e {RD_IDLE, RD_STREAM}, and a function computing S.
- Sub-module operand_bank_rf: single register-file bank with one serial write port and CHANNELS parallel read ports, addressed by lane and element. Instantiated twice.

Test Plan:
- CHANNELS=4, DEPTH=3, DATA_WIDTH=16. Write 1..12, start → lane0 gives 1,2,3 in cycles 1-3; lane3 gives 10,11,12 in cycles 4-6; last_o[3] in cycle 6; done_o in cycle 7.
- Fill bank A (1..12) then bank B (101..112) while A streams → full_banks_o goes 1→2→1; second start in cycle 7 streams 101.. with lane0 in cycle 8.
- Fill both banks, then 3 extra writes → wr_ready_o=0, wr_overflow_o=1 sticky, stored data unchanged on subsequent streams.
- stall_i high for cycles 2-3 of a stream → outputs held; done_o moves from cycle 7 to cycle 9.
- 5 writes then wr_reset_i, then 12 writes 201..212 → stream yields 201.. on lane0.
- Assert rst_i in cycle 3 of a stream → next cycle all outputs 0, full_banks_o=0, no done_o; start_i is ignored afterwards.
